// File: rtl/cache_pkg.sv
// Cache-side shared definitions: arbiter grant states and the default icache starvation limit.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        D_GNT,
        I_GNT
    } arb_state_t;

    localparam int ARB_STARVE_LIMIT = 4;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: the memory word and the RAM handshake state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache; dcache-first with an icache starvation guard.
// Optional ARB_STATS_EN adds per-side completed-word counters igrant_cnt/dgrant_cnt.
module mem_arbiter
    import cpu_types_pkg::*;
    import cache_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
    parameter int CNT_W        = 3
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
`ifdef ARB_STATS_EN
    output word_t     igrant_cnt,
    output word_t     dgrant_cnt,
`endif
    output logic      bus_err
);

    arb_state_t       state, next_state;
    logic [CNT_W-1:0] istarve_cnt;
    logic             d_req, ram_done, starved, d_done, i_done;

    assign d_req    = dREN | dWEN;
    assign ram_done = (ramstate == ACCESS) || (ramstate == ERROR);
    assign starved  = iREN && (istarve_cnt == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // A granted side that drops its request aborts back to IDLE without completing.
    always_comb begin
        next_state = state;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        d_done     = 1'b0;
        i_done     = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !starved) next_state = D_GNT;
                else if (iREN)         next_state = I_GNT;
            end
            D_GNT: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_req) begin
                    next_state = IDLE;
                end else if (ram_done) begin
                    dwait      = 1'b0;
                    dload      = ramload;
                    d_done     = 1'b1;
                    next_state = IDLE;
                end
            end
            I_GNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (ram_done) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    i_done     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Saturating count of dcache words served while the icache keeps waiting.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST)                 istarve_cnt <= '0;
        else if (!iREN || i_done)  istarve_cnt <= '0;
        else if (d_done && (istarve_cnt != CNT_W'(STARVE_LIMIT)))
                                   istarve_cnt <= istarve_cnt + 1'b1;
    end

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST)                                       bus_err <= 1'b0;
        else if ((d_done || i_done) && ramstate == ERROR) bus_err <= 1'b1;
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            igrant_cnt <= '0;
            dgrant_cnt <= '0;
        end else begin
            if (i_done) igrant_cnt <= igrant_cnt + 1'b1;
            if (d_done) dgrant_cnt <= dgrant_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int LIMIT = 4;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    word_t     iload, dload, ramaddr, ramstore;
    logic      iwait, dwait, ramREN, ramWEN, bus_err;
`ifdef ARB_STATS_EN
    word_t     igrant_cnt, dgrant_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the RAM (0 none, 1 dcache, 2 icache) plus side counters.
    int    m_owner;
    int    m_starve;
    logic  m_berr;
    word_t m_icnt, m_dcnt;

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
`ifdef ARB_STATS_EN
        .igrant_cnt(igrant_cnt), .dgrant_cnt(dgrant_cnt),
`endif
        .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ir, input word_t ia, input logic dr, input logic dw,
                                 input word_t da, input word_t ds, input ramstate_t rs, input word_t rl);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
        daddr = da; dstore = ds; ramstate = rs; ramload = rl;
    endtask

    task automatic resetModel();
        m_owner = 0; m_starve = 0; m_berr = 1'b0; m_icnt = '0; m_dcnt = '0;
    endtask

    // Expected combinational view of the current cycle, derived from ownership and live inputs.
    task automatic compareModel();
        logic  e_ren, e_wen, e_iw, e_dw, rdone;
        word_t e_addr, e_store, e_iload, e_dload;
        if (!nRST) resetModel();
        rdone = (ramstate == ACCESS) || (ramstate == ERROR);
        e_ren = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
        e_addr = '0; e_store = '0; e_iload = '0; e_dload = '0;
        if (m_owner == 1) begin
            e_ren = dREN & ~dWEN; e_wen = dWEN; e_addr = daddr; e_store = dstore;
            if ((dREN | dWEN) && rdone) begin e_dw = 1'b0; e_dload = ramload; end
        end else if (m_owner == 2) begin
            e_ren = iREN; e_addr = iaddr;
            if (iREN && rdone) begin e_iw = 1'b0; e_iload = ramload; end
        end
        checkOutput("iwait", iwait, e_iw);
        checkOutput("dwait", dwait, e_dw);
        checkOutput("ramREN", ramREN, e_ren);
        checkOutput("ramWEN", ramWEN, e_wen);
        checkOutput("ramaddr", ramaddr, e_addr);
        checkOutput("ramstore", ramstore, e_store);
        checkOutput("iload", iload, e_iload);
        checkOutput("dload", dload, e_dload);
        checkOutput("bus_err", bus_err, m_berr);
`ifdef ARB_STATS_EN
        checkOutput("igrant_cnt", igrant_cnt, m_icnt);
        checkOutput("dgrant_cnt", dgrant_cnt, m_dcnt);
`endif
    endtask

    task automatic modelStep();
        logic rdone, d_done, i_done, dreq;
        int   nxt;
        dreq   = dREN | dWEN;
        rdone  = (ramstate == ACCESS) || (ramstate == ERROR);
        d_done = (m_owner == 1) && dreq && rdone;
        i_done = (m_owner == 2) && iREN && rdone;
        nxt = m_owner;
        if (m_owner == 0) begin
            if (dreq && !(iREN && m_starve == LIMIT)) nxt = 1;
            else if (iREN)                             nxt = 2;
        end else if (m_owner == 1) begin
            if (!dreq || d_done) nxt = 0;
        end else begin
            if (!iREN || i_done) nxt = 0;
        end
        if ((d_done || i_done) && ramstate == ERROR) m_berr = 1'b1;
        if (d_done) m_dcnt = m_dcnt + 1;
        if (i_done) m_icnt = m_icnt + 1;
        if (!iREN || i_done)              m_starve = 0;
        else if (d_done && m_starve < LIMIT) m_starve++;
        m_owner = nxt;
    endtask

    task automatic settle();
        #3;
        compareModel();
    endtask

    task automatic advance();
        if (nRST) modelStep();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seq[$];
        int pulses;
        resetModel();
        nRST = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, FREE, '0);
        @(posedge CLK); #1;

        // Reset held with iREN pending, then first icache word.
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, '0, '0, FREE, '0);
        settle();
        checkOutput("rst_iwait", iwait, 1'b1);
        checkOutput("rst_ramREN", ramREN, 1'b0);
        advance();
        nRST = 1'b1;
        settle();
        checkOutput("t1_idle_iwait", iwait, 1'b1);
        advance();
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, '0, '0, ACCESS, 32'h2000_0001);
        settle();
        checkOutput("t1_ramREN", ramREN, 1'b1);
        checkOutput("t1_iwait", iwait, 1'b0);
        checkOutput("t1_iload", iload, 32'h2000_0001);
        advance();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, FREE, '0);
        settle(); advance();

        // Simultaneous requests: dcache wins, icache waits throughout.
        applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h3100, '0, BUSY, 32'h1234_5678);
        settle(); advance();
        for (int k = 0; k < 3; k++) begin
            settle();
            checkOutput("t2_ramaddr", ramaddr, 32'h3100);
            checkOutput("t2_iwait", iwait, 1'b1);
            advance();
        end
        ramstate = ACCESS;
        settle();
        checkOutput("t2_dwait", dwait, 1'b0);
        checkOutput("t2_iwait_done", iwait, 1'b1);
        advance();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, FREE, '0);
        settle(); advance();

        // Starvation guard: icache forced in after LIMIT dcache words.
        applyStimulus(1'b1, 32'h0000_0300, 1'b0, 1'b1, 32'h0000_0800, 32'h5555_AAAA, ACCESS, 32'h0BAD_F00D);
        for (int k = 0; k < 30 && seq.size() < 6; k++) begin
            settle();
            if (dwait == 1'b0) seq.push_back(1);
            if (iwait == 1'b0) seq.push_back(2);
            advance();
        end
        checkOutput("t3_words", seq.size(), 6);
        for (int k = 0; k < seq.size() && k < 6; k++)
            checkOutput($sformatf("t3_order%0d", k), seq[k], (k == 4) ? 2 : 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, FREE, '0);
        settle(); advance();

        // Write held through BUSY: address/data stable, single dwait pulse.
        pulses = 0;
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h0040, 32'hDEAD_BEEF, BUSY, '0);
        settle(); advance();
        for (int k = 0; k < 3; k++) begin
            settle();
            checkOutput("t4_ramWEN", ramWEN, 1'b1);
            checkOutput("t4_ramaddr", ramaddr, 32'h0040);
            checkOutput("t4_ramstore", ramstore, 32'hDEAD_BEEF);
            if (dwait == 1'b0) pulses++;
            advance();
        end
        ramstate = ACCESS;
        settle();
        if (dwait == 1'b0) pulses++;
        advance();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, FREE, '0);
        settle();
        if (dwait == 1'b0) pulses++;
        advance();
        checkOutput("t4_dwait_pulses", pulses, 1);

        // ERROR completion on the icache side makes bus_err sticky.
        applyStimulus(1'b1, 32'h0000_0400, 1'b0, 1'b0, '0, '0, FREE, '0);
        settle(); advance();
        ramstate = ERROR;
        settle();
        checkOutput("t5_iwait", iwait, 1'b0);
        advance();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, FREE, '0);
        for (int k = 0; k < 3; k++) begin
            settle();
            checkOutput("t5_bus_err", bus_err, 1'b1);
            advance();
        end

        // Random traffic with request hold bias.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(3) == 0) iREN = $urandom_range(1);
            if ($urandom_range(3) == 0) dREN = $urandom_range(1);
            if ($urandom_range(3) == 0) dWEN = ($urandom_range(2) == 0);
            if ($urandom_range(3) == 0) iaddr = $urandom;
            if ($urandom_range(3) == 0) daddr = $urandom;
            if ($urandom_range(3) == 0) dstore = $urandom;
            ramload = $urandom;
            case ($urandom_range(19))
                0, 1:              ramstate = FREE;
                2, 3, 4, 5, 6, 7,
                8, 9:              ramstate = BUSY;
                19:                ramstate = ERROR;
                default:           ramstate = ACCESS;
            endcase
            settle(); advance();
        end

        // Async reset in the middle of a dcache write.
        nRST = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, FREE, '0);
        settle();
        checkOutput("t6_rst_bus_err", bus_err, 1'b0);
        advance();
        nRST = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h0000_0900, 32'hCAFE_0001, BUSY, '0);
        settle(); advance();
        settle();
        checkOutput("t6_pre_ramWEN", ramWEN, 1'b1);
        nRST = 1'b0;
        #1;
        checkOutput("t6_ramWEN", ramWEN, 1'b0);
        checkOutput("t6_dwait", dwait, 1'b1);
        resetModel();
`ifdef ARB_STATS_EN
        checkOutput("t6_dgrant_cnt", dgrant_cnt, 32'd0);
`endif
        @(posedge CLK); #1;
        nRST = 1'b1;
        settle();
        checkOutput("t6_idle_ramWEN", ramWEN, 1'b0);
        advance();
        settle(); advance();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
